// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Holds the FSM encoding, bus width and the default starvation/timeout limits.
package mem_arbiter_pkg;

    localparam int XLEN           = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_sel.sv
// Grant decision between fetch and data ports: data first unless fetch is starved.
// Latency: purely combinational.
// Backpressure: none; the caller only samples the grant while idle.
module mem_arbiter_sel #(
    parameter int STARVE_MAX = 4,
    parameter int SW         = 3
) (
    input  logic          i_req,
    input  logic          d_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_i,
    output logic          grant_d
);

    logic starved;

    assign starved = i_req && (starve_cnt == SW'(STARVE_MAX));
    assign grant_d = d_req && !starved;
    assign grant_i = i_req && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/ack memory bus between the instruction-fetch and data ports.
// Latency: grant -> bus_req next cycle -> valid pulse the cycle after bus_ack.
// Backpressure: one transaction at a time; request inputs are ignored while busy.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] im_addr,
    output logic            im_valid,
    output logic [XLEN-1:0] im_data,
    input  logic            d_req,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            mem_write,
    input  logic [XLEN-1:0] mem_write_data,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_read_data,
    output logic            bus_req,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            bus_err
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    arb_state_t      state, state_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   to_cnt;
    logic [XLEN-1:0] i_tag;
    logic            grant_i, grant_d;
    logic            ack_ok, abort;

    mem_arbiter_sel #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ack in the expiry cycle is checked first so it wins over the abort.
    always_comb begin
        state_nxt = state;
        ack_ok    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = D_BUSY;
                end else if (grant_i) begin
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus_ack) begin
                    ack_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_req = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_valid      <= 1'b0;
            im_data       <= '0;
            mem_valid     <= 1'b0;
            mem_read_data <= '0;
            bus_addr      <= '0;
            bus_we        <= 1'b0;
            bus_wdata     <= '0;
            bus_err       <= 1'b0;
            i_tag         <= '0;
            starve_cnt    <= '0;
            to_cnt        <= '0;
        end else begin
            im_valid  <= 1'b0;
            mem_valid <= 1'b0;
            bus_err   <= abort;
            if (state == IDLE) begin
                if (grant_d) begin
                    bus_addr  <= mem_addr;
                    bus_we    <= mem_write;
                    bus_wdata <= mem_write_data;
                    to_cnt    <= '0;
                    if (!i_req) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_TOP) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end else if (grant_i) begin
                    bus_addr   <= im_addr;
                    bus_we     <= 1'b0;
                    bus_wdata  <= '0;
                    i_tag      <= im_addr;
                    to_cnt     <= '0;
                    starve_cnt <= '0;
                end
            end else if (ack_ok) begin
                if (state == D_BUSY) begin
                    mem_valid     <= 1'b1;
                    mem_read_data <= bus_we ? '0 : bus_rdata;
                end else if (i_req && (im_addr == i_tag)) begin
                    // A redirected fetch is dropped without a pulse.
                    im_valid <= 1'b1;
                    im_data  <= bus_rdata;
                end
            end else if (!abort) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a bus responder model and valid-pulse scoreboard.
module tb_mem_arbiter;

    logic        clk, rst_n;
    logic        i_req, d_req, mem_write, bus_ack;
    logic [31:0] im_addr, mem_addr, mem_write_data, bus_rdata;
    logic        im_valid, mem_valid, bus_req, bus_we, bus_err;
    logic [31:0] im_data, mem_read_data, bus_addr, bus_wdata;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .im_addr(im_addr), .im_valid(im_valid), .im_data(im_data),
        .d_req(d_req), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_valid(mem_valid), .mem_read_data(mem_read_data),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] im_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] grant_log[$];
    int          req_cycles = 0;
    int          err_cnt    = 0;
    int          mval_cnt   = 0;
    logic        prev_req   = 1'b0;

    logic ack_en    = 1'b1;
    logic force_ack = 1'b0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory responder: acks after ack_delay req cycles; stores update the model.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (force_ack) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'hBAD0_BAD0;
            end else if (ack_en && bus_req) begin
                if (wait_cnt >= ack_delay) begin
                    bus_ack = 1'b1;
                    if (bus_we) begin
                        mem[bus_addr] = bus_wdata;
                        bus_rdata     = 32'hFFFF_FFFF;
                    end else begin
                        bus_rdata = rd_model(bus_addr);
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Output monitor sampled just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus_req && !prev_req) grant_log.push_back(bus_addr);
            prev_req = bus_req;
            if (bus_req) req_cycles++;
            if (bus_err) err_cnt++;
            if (im_valid) begin
                if (im_q.size() == 0) check("im_spurious", 32'(im_valid), 32'd0);
                else                  check("im_data", im_data, im_q.pop_front());
            end
            if (mem_valid) begin
                mval_cnt++;
                if (mem_q.size() == 0) check("mem_spurious", 32'(mem_valid), 32'd0);
                else                   check("mem_read_data", mem_read_data, mem_q.pop_front());
            end
        end
    end

    task automatic data_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [31:0] exp);
        @(negedge clk);
        d_req = 1'b1; mem_addr = a; mem_write = we; mem_write_data = wd;
        mem_q.push_back(exp);
        @(negedge clk);
        d_req = 1'b0;
        check("d_bus_req", 32'(bus_req), 32'd1);
        check("d_bus_addr", bus_addr, a);
        check("d_bus_we", 32'(bus_we), 32'(we));
        if (we) check("d_bus_wdata", bus_wdata, wd);
        for (int i = 0; i < 30 && mem_q.size() != 0; i++) @(negedge clk);
        check("d_done", 32'(mem_q.size()), 32'd0);
    endtask

    initial begin
        int base, r0, e0, m0;
        i_req = 0; d_req = 0; mem_write = 0;
        im_addr = 0; mem_addr = 0; mem_write_data = 0;
        mem[32'h100] = 32'h0050_0093;
        mem[32'h200] = 32'h1234_5678;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flags", {27'b0, im_valid, mem_valid, bus_req, bus_we, bus_err}, 32'd0);
        check("rst_im_data", im_data, 32'd0);
        check("rst_mem_rd", mem_read_data, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lone fetch with ack in the first req cycle: valid in the third cycle.
        i_req = 1'b1; im_addr = 32'h100;
        im_q.push_back(32'h0050_0093);
        @(negedge clk);
        check("f_bus_req", 32'(bus_req), 32'd1);
        check("f_bus_addr", bus_addr, 32'h100);
        check("f_bus_we", 32'(bus_we), 32'd0);
        check("f_bus_wdata", bus_wdata, 32'd0);
        check("f_early_valid", 32'(im_valid), 32'd0);
        @(negedge clk);
        check("f_im_valid", 32'(im_valid), 32'd1);
        check("f_im_data", im_data, 32'h0050_0093);
        i_req = 1'b0;
        @(negedge clk);
        check("f_pulse_len", 32'(im_valid), 32'd0);
        check("f_bus_idle", 32'(bus_req), 32'd0);

        // Store then load back.
        ack_delay = 1;
        data_txn(32'h2000, 1'b1, 32'hDEAD_BEEF, 32'h0);
        data_txn(32'h2000, 1'b0, 32'h0, 32'hDEAD_BEEF);
        ack_delay = 0;

        // Contention: both ports held high.
        @(negedge clk);
        base = grant_log.size();
        im_addr = 32'h100; mem_addr = 32'h3000; mem_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) im_q.push_back(32'h0050_0093);
            else            mem_q.push_back(32'h3000 ^ 32'hA5A5_0000);
        end
        i_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 200 && (im_q.size() != 0 || mem_q.size() != 0); i++) @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        check("c_grants", 32'(grant_log.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < grant_log.size())
                check("c_order_is_i", 32'(grant_log[base+i] == 32'h100), 32'(i % 5 == 4));
        end
        repeat (3) @(negedge clk);

        // Redirect mid-fetch.
        ack_delay = 2;
        base = grant_log.size();
        i_req = 1'b1; im_addr = 32'h100;
        @(negedge clk);
        check("r_bus_addr0", bus_addr, 32'h100);
        im_addr = 32'h200;
        for (int i = 0; i < 30 && grant_log.size() < base + 2; i++) @(negedge clk);
        check("r_regrant", 32'(grant_log.size() - base), 32'd2);
        check("r_bus_addr1", bus_addr, 32'h200);
        im_q.push_back(32'h1234_5678);
        for (int i = 0; i < 30 && im_q.size() != 0; i++) @(negedge clk);
        i_req = 1'b0;
        check("r_done", 32'(im_q.size()), 32'd0);
        ack_delay = 0;
        repeat (2) @(negedge clk);

        // Timeout with no ack.
        ack_en = 1'b0;
        r0 = req_cycles; e0 = err_cnt; m0 = mval_cnt;
        d_req = 1'b1; mem_addr = 32'h4000; mem_write = 1'b0;
        @(negedge clk);
        d_req = 1'b0;
        for (int i = 0; i < 400 && err_cnt == e0; i++) @(negedge clk);
        check("t_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t_req_cycles", 32'(req_cycles - r0), 32'd255);
        check("t_bus_req_low", 32'(bus_req), 32'd0);
        @(negedge clk);
        check("t_err_len", 32'(bus_err), 32'd0);
        check("t_no_valid", 32'(mval_cnt - m0), 32'd0);
        ack_en = 1'b1;
        data_txn(32'h4000, 1'b0, 32'h0, 32'h4000 ^ 32'hA5A5_0000);

        // Reset during a data transaction, then a stray ack.
        ack_en = 1'b0;
        @(negedge clk);
        d_req = 1'b1; mem_addr = 32'h5000; mem_write = 1'b1; mem_write_data = 32'hCAFE_F00D;
        @(negedge clk);
        d_req = 1'b0;
        repeat (3) @(negedge clk);
        check("x_busy", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("x_rst_flags", {27'b0, im_valid, mem_valid, bus_req, bus_we, bus_err}, 32'd0);
        check("x_rst_addr", bus_addr, 32'd0);
        check("x_rst_wdata", bus_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m0 = mval_cnt;
        @(negedge clk);
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("x_stray_ack", 32'(mval_cnt - m0), 32'd0);
        check("x_idle", 32'(bus_req), 32'd0);
        ack_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one external unified memory bus between the pipeline's instruction-fetch port and its data (memory-stage) port. Sits between the cpu top and the memory/bus model, replacing two separate memories. It latches one request per transaction, sequences it on the bus with a req/ack handshake, and returns a one-cycle valid pulse with read data to the winning port. Arbitration gives data priority, with an anti-starvation counter that guarantees fetch progress.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win.
TIMEOUT, 255, bus_req cycles without bus_ack before the transaction is aborted.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_n  input  1  asynchronous active-low reset.
i_req  input  1  fetch wants an instruction.
im_addr  input  32  fetch address.
im_valid  output  1  one-cycle pulse: im_data is valid for the current im_addr.
im_data  output  32  instruction word.
d_req  input  1  memory stage has a load or store.
mem_addr  input  32  data address.
mem_write  input  1  1 = store, 0 = load.
mem_write_data  input  32  store data.
mem_valid  output  1  one-cycle pulse: data transaction complete.
mem_read_data  output  32  load data; 0 for stores.
bus_req  output  1  transaction active; held until bus_ack or timeout.
bus_addr  output  32  latched address.
bus_we  output  1  latched write enable.
bus_wdata  output  32  latched write data.
bus_ack  input  1  one-cycle completion from memory.
bus_rdata  input  32  read data, valid with bus_ack.
bus_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: FSM=IDLE; every output 0; starvation and timeout counters 0.
- FSM states: IDLE, I_BUSY, D_BUSY.
- In IDLE, with d_req and !(i_req && starve_cnt==STARVE_MAX): grant D. Else with i_req: grant I. Else stay in IDLE.
- On grant, latch bus_addr, bus_we and bus_wdata from the winner. For I: bus_we=0 and bus_wdata=0. Register the fetch address as i_tag. bus_req rises the cycle after the grant decision.
- Each BUSY state holds bus_req and the latched fields stable until bus_ack. Changes on the request-side inputs are ignored while busy.
- On bus_ack in D_BUSY:
  - the next cycle, mem_valid=1 for one cycle;
  - mem_read_data = bus_rdata for loads, 0 for stores;
  - FSM returns to IDLE.
- On bus_ack in I_BUSY:
  - if im_addr==i_tag and i_req, the next cycle im_valid=1 for one cycle and im_data=bus_rdata;
  - otherwise (branch redirect mid-fetch) the result is discarded silently;
  - FSM returns to IDLE.
- Bus protocol: one idle cycle (bus_req=0) separates back-to-back transactions. Minimum turnaround is 3 cycles from request to valid when memory acks in the first req cycle.
- starve_cnt:
  - increments, saturating at STARVE_MAX, on a D grant while i_req=1;
  - clears on an I grant;
  - clears on a D grant while i_req=0.
- Timeout counter:
  - clears at each grant and increments each BUSY cycle without bus_ack;
  - when it reaches TIMEOUT, bus_req drops, bus_err pulses for one cycle and the FSM returns to IDLE;
  - no valid pulse is issued for the aborted transaction;
  - a bus_ack in the same cycle as expiry counts as success: no bus_err.
- Simultaneous i_req and d_req in IDLE: D wins unless the starvation limit has been reached.
- Reset mid-transaction: immediate return to IDLE with bus_req=0. Any later bus_ack arriving in IDLE is ignored.
- im_data and mem_read_data hold their last value between valid pulses, except mem_read_data, which is 0 after stores.

Decomposition:
- Shared package: FSM state encoding, the STARVE_MAX and TIMEOUT defaults, and the bus field widths (XLEN=32).
- One sub-module is natural: mem_arbiter_sel, a combinational priority/starvation grant decision driven by i_req, d_req and starve_cnt. The FSM, latches and counters stay in the top module.

Test Plan:
- Lone fetch: i_req=1, im_addr=0x100, memory acks on the 1st req cycle with 0x00500093 -> bus_addr=0x100, bus_we=0; im_valid pulses 3 cycles after the request with im_data=0x00500093.
- Store then load: d_req with mem_write=1, addr 0x2000, data 0xDEADBEEF, then a load from 0x2000 -> bus_we=1, bus_wdata=0xDEADBEEF; mem_valid pulses with 0; the load returns mem_read_data=0xDEADBEEF.
- Contention/starvation: i_req and d_req held high continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; im_valid fires every 5th transaction.
- Redirect mid-fetch: fetch at 0x100 granted; im_addr changes to 0x200 before bus_ack -> no im_valid for 0x100; the next grant uses bus_addr=0x200.
- Timeout: bus_ack never asserted, TIMEOUT=255 -> bus_req drops and bus_err pulses after 255 req cycles; no valid pulse; next request is granted normally.
- Reset mid-operation: rst_n low during D_BUSY -> all outputs 0 immediately; a stray bus_ack after release produces no mem_valid.
